stall_ctrl: RTL

- Pipeline stall controller; drives the 6-bit stall vector consumed by every inter-stage register (pc, if_id, id_ex, ex_mem, mem_wb).
- Merges the single-cycle load-use stall request from ID with multi-cycle execute operations (mult-acc, div) announced by EX.
- Holds the EX stall for a counted number of cycles, or until early completion.
- Keeps a saturating stall-cycle performance counter and a sticky protocol-error flag.

---
 rtl/stall_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: merges ID load-use holds with counted
// multi-cycle EX holds, plus a stall-cycle counter and error flag.
module stall_ctrl #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              mc_start,
  input  logic [CNT_W-1:0]  mc_cycles,
  input  logic              mc_done,
  input  logic              perf_clr,
  output logic [5:0]        stall,
  output logic              ex_busy,
  output logic [PERF_W-1:0] stall_count,
  output logic              proto_err
);

  localparam logic [5:0] PAT_EX   = 6'b001111;
  localparam logic [5:0] PAT_ID   = 6'b000111;
  localparam logic [5:0] PAT_NONE = 6'b000000;

  typedef enum logic {
    IDLE    = 1'b0,
    EX_WAIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PERF_W-1:0]  perf_q, perf_d;
  logic               err_q, err_d;

  logic mc_len0, mc_len1;

  assign mc_len0 = (mc_cycles == '0);
  assign mc_len1 = (mc_cycles == CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      perf_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perf_q  <= perf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (mc_start && !mc_len0 && !mc_len1) begin
          state_d = EX_WAIT;
          cnt_d   = mc_cycles - CNT_W'(1);
        end
      end
      EX_WAIT: begin
        if (mc_done || cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Gated by reset so no stall leaks out while rst is held low.
  always_comb begin
    stall   = PAT_NONE;
    ex_busy = 1'b0;
    if (rst) begin
      unique case (state_q)
        IDLE: begin
          if (mc_start && !mc_len0) begin
            stall   = PAT_EX;
            ex_busy = 1'b1;
          end else if (stallreq_id) begin
            stall = PAT_ID;
          end
        end
        EX_WAIT: begin
          stall   = PAT_EX;
          ex_busy = 1'b1;
        end
        default: begin
          stall   = PAT_NONE;
          ex_busy = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    err_d = err_q;
    if (mc_start && (state_q == EX_WAIT || (&mc_cycles)))
      err_d = 1'b1;
  end

  always_comb begin
    perf_d = perf_q;
    if (perf_clr)
      perf_d = '0;
    else if (stall[0] && !(&perf_q))
      perf_d = perf_q + PERF_W'(1);
  end

  assign stall_count = perf_q;
  assign proto_err   = err_q;

endmodule
